mul_sched: RTL and testbench

- Sequencer and round-robin arbiter that shares one repeated-addition multiplier datapath (A register, P accumulator, B down-counter, zero detect) among NREQ requesters.
- Accepts operand pairs over a req/ack handshake and drives the datapath load, clear and decrement strobes plus the operand bus.
- Watches the datapath's eqz flag and returns the tagged product on a one-cycle response strobe.
- Sits directly above the datapath.

---
 rtl/mul_sched.sv | 81 ++++++++
 tb/tb_mul_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_sched.sv
// mul_sched: round-robin sequencer that shares one repeated-addition multiplier
// datapath among NREQ requesters and returns the tagged product.
module mul_sched #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   ack,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_data,
  output logic              busy,
  output logic [W-1:0]      bus_out,
  output logic              LdA,
  output logic              LdB,
  output logic              LdP,
  output logic              clrP,
  output logic              decB,
  input  logic              eqz,
  input  logic [W-1:0]      p_in
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, id, win;
  logic found;
  logic [W-1:0] a_q, b_q;
  // first requester strictly after the last winner, wrapping around
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE   ? (found ? LOAD_A : IDLE) :
               state == LOAD_A ? LOAD_B :
               state == LOAD_B ? ACCUM :
               state == ACCUM  ? (eqz ? DONE : ACCUM) : IDLE;
    ack = (state == LOAD_A) ? NREQ'(1) << id : '0;
    bus_out = state == LOAD_A ? a_q : state == LOAD_B ? b_q : '0;
    LdA = state == LOAD_A;
    LdB = state == LOAD_B;
    clrP = state == LOAD_B;
    LdP = state == ACCUM && !eqz;
    decB = state == ACCUM && !eqz;
    resp_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= IDW'(NREQ - 1);
      id <= '0;
      a_q <= '0;
      b_q <= '0;
      resp_id <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        ptr <= win;
        id <= win;
        a_q <= a_in[int'(win)*W +: W];
        b_q <= b_in[int'(win)*W +: W];
      end
      if (state == ACCUM && eqz) begin
        resp_data <= p_in;
        resp_id <= id;
      end
    end
  end
endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: scoreboard bench for mul_sched with a behavioural multiplier datapath.
module tb_mul_sched;
  localparam int NREQ = 4, W = 16, IDW = 2;
  logic clk = 1'b0, rst;
  logic [NREQ-1:0] req, ack;
  logic [NREQ*W-1:0] a_in, b_in;
  logic resp_valid, busy, LdA, LdB, LdP, clrP, decB, eqz;
  logic [IDW-1:0] resp_id;
  logic [W-1:0] resp_data, bus_out, p_in;
  logic [W-1:0] d_a, d_p, d_b;
  logic [31:0] jq[NREQ][$];
  logic [23:0] sb[$];
  int grants[$];
  int nerr = 0, nchk = 0, cyc = 0, resp_cnt = 0, resp_cyc = 0, ack_cyc = 0;
  int ldp_cnt = 0, clrp_cnt = 0, idle_cnt = 0, t0 = 0, n0 = 0;
  int exp_order[5] = '{0, 1, 2, 3, 0};
  mul_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .ack(ack),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .busy(busy),
    .bus_out(bus_out), .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
    .eqz(eqz), .p_in(p_in)
  );
  always #5 clk = ~clk;
  // datapath environment: A register, P accumulator, B down-counter
  assign eqz = d_b == '0;
  assign p_in = d_p;
  always @(posedge clk) begin
    if (LdA) d_a <= bus_out;
    if (LdB) d_b <= bus_out;
    if (decB) d_b <= d_b - 1'b1;
    if (clrP) d_p <= '0;
    if (LdP) d_p <= d_p + d_a;
  end
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({ack, resp_valid, resp_id, resp_data, busy, bus_out, LdA, LdB, LdP, clrP, decB});
  endfunction
  task automatic step();
    int g;
    logic [31:0] job, prod;
    logic [23:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (|ack) begin
      g = 0;
      for (int i = 0; i < NREQ; i++) if (ack[i]) g = i;
      check("ack_onehot", 64'($onehot(ack)), 64'd1);
      check("ack_req", 64'(req[g]), 64'd1);
      grants.push_back(g);
      ack_cyc = cyc;
      if (jq[g].size() > 0) begin
        job = jq[g].pop_front();
        prod = job[31:16] * job[15:0];
        sb.push_back({g[7:0], prod[15:0]});
      end
      if (jq[g].size() > 0) begin
        a_in[g*W +: W] = jq[g][0][31:16];
        b_in[g*W +: W] = jq[g][0][15:0];
      end else req[g] = 1'b0;
    end
    if (resp_valid) begin
      resp_cnt++;
      resp_cyc = cyc;
      if (sb.size() == 0) check("resp_spurious", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("resp_id", 64'(resp_id), 64'(e[23:16]));
        check("resp_data", 64'(resp_data), 64'(e[15:0]));
      end
    end
    if (LdP != decB) check("ldp_decb", 64'(LdP), 64'(decB));
    ldp_cnt += int'(LdP);
    clrp_cnt += int'(clrP);
    if (!busy) idle_cnt++;
  endtask
  task automatic submit(int i, logic [15:0] a, logic [15:0] b);
    jq[i].push_back({a, b});
    if (!req[i]) begin
      req[i] = 1'b1;
      a_in[i*W +: W] = a;
      b_in[i*W +: W] = b;
    end
  endtask
  task automatic wait_resp(int n, int budget);
    int target, k;
    target = resp_cnt + n;
    k = 0;
    while (resp_cnt < target && k < budget) begin
      step();
      k++;
    end
    check("resp_timeout", 64'(resp_cnt >= target), 64'd1);
  endtask
  task automatic flush();
    req = '0;
    sb.delete();
    grants.delete();
    for (int i = 0; i < NREQ; i++) jq[i].delete();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_outs", outs(), 64'd0);
    flush();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic single(string tag, int i, logic [15:0] a, logic [15:0] b);
    step();
    t0 = cyc;
    ldp_cnt = 0;
    clrp_cnt = 0;
    submit(i, a, b);
    wait_resp(1, int'(b) + 20);
    check({tag, "_ack_lat"}, 64'(ack_cyc - t0), 64'd1);
    check({tag, "_lat"}, 64'(resp_cyc - t0), 64'(int'(b) + 4));
    check({tag, "_ldp"}, 64'(ldp_cnt), 64'(b));
    check({tag, "_clrp"}, 64'(clrp_cnt), 64'd1);
  endtask
  initial begin
    rst = 1'b1;
    req = '0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    single("t1", 0, 16'd7, 16'd5);
    single("t2", 1, 16'd123, 16'd0);
    single("t3a", 2, 16'd300, 16'd300);
    single("t3b", 2, 16'd0, 16'd9);
    do_reset();
    submit(0, 16'd2, 16'd3);
    submit(2, 16'd4, 16'd1);
    repeat (3) step();
    submit(0, 16'd3, 16'd3);
    wait_resp(3, 100);
    check("t4_ngrant", 64'(grants.size()), 64'd3);
    if (grants.size() == 3) begin
      check("t4_g0", 64'(grants[0]), 64'd0);
      check("t4_g1", 64'(grants[1]), 64'd2);
      check("t4_g2", 64'(grants[2]), 64'd0);
    end
    do_reset();
    submit(0, 16'd1, 16'd2);
    submit(0, 16'd5, 16'd1);
    submit(1, 16'd2, 16'd2);
    submit(2, 16'd3, 16'd3);
    submit(3, 16'd4, 16'd4);
    idle_cnt = 0;
    wait_resp(5, 200);
    check("t5_ngrant", 64'(grants.size()), 64'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++) check("t5_order", 64'(grants[i]), 64'(exp_order[i]));
    check("t5_idle", 64'(idle_cnt), 64'd4);
    do_reset();
    submit(0, 16'd5, 16'd10);
    ldp_cnt = 0;
    for (int k = 0; k < 30 && ldp_cnt < 4; k++) step();
    check("t6_adds", 64'(ldp_cnt), 64'd4);
    rst = 1'b1;
    #1;
    check("t6_async_outs", outs(), 64'd0);
    flush();
    n0 = resp_cnt;
    repeat (2) step();
    rst = 1'b0;
    repeat (15) step();
    check("t6_no_resp", 64'(resp_cnt), 64'(n0));
    check("t6_no_grant", 64'(grants.size()), 64'd0);
    single("t6r", 0, 16'd5, 16'd10);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
